// File: rtl/carfield_mbox_fifo.sv
// Carfield mailbox: host port (a) and island port (b) exchange words through two
// independent FIFOs (AB: a->b, BA: b->a), with per-side status, threshold IRQ and flush.
module carfield_mbox_fifo #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 8,
    parameter int unsigned AddrWidth = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 a_req_i,
    input  logic                 a_we_i,
    input  logic [AddrWidth-1:0] a_addr_i,
    input  logic [DataWidth-1:0] a_wdata_i,
    output logic                 a_gnt_o,
    output logic                 a_rvalid_o,
    output logic [DataWidth-1:0] a_rdata_o,
    output logic                 a_err_o,
    output logic                 a_irq_o,
    input  logic                 b_req_i,
    input  logic                 b_we_i,
    input  logic [AddrWidth-1:0] b_addr_i,
    input  logic [DataWidth-1:0] b_wdata_i,
    output logic                 b_gnt_o,
    output logic                 b_rvalid_o,
    output logic [DataWidth-1:0] b_rdata_o,
    output logic                 b_err_o,
    output logic                 b_irq_o
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = $clog2(Depth) + 1;
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);

    typedef enum logic [2:0] {
        RegTxData = 3'd0,
        RegRxData = 3'd1,
        RegStatus = 3'd2,
        RegIrqEn  = 3'd3,
        RegThresh = 3'd4,
        RegClr    = 3'd5,
        RegNone   = 3'd7
    } reg_e;

    // Index 0 is side a / FIFO AB, index 1 is side b / FIFO BA.
    // Side s pushes FIFO s and pops FIFO 1-s.
    logic [1:0]                req, we;
    logic [1:0][AddrWidth-1:0] addr;
    logic [1:0][DataWidth-1:0] wdata;

    assign req   = {b_req_i, a_req_i};
    assign we    = {b_we_i, a_we_i};
    assign addr  = {b_addr_i, a_addr_i};
    assign wdata = {b_wdata_i, a_wdata_i};

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{a_addr_i[1:0], b_addr_i[1:0]};

    logic [DataWidth-1:0]      mem_q [2][Depth];
    logic [1:0][PtrWidth-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0][CntWidth-1:0]  cnt_q, cnt_d, thresh_q, thresh_d;
    logic [1:0]                irq_en_q, irq_en_d, ovf_q, ovf_d, irq_q, irq_d;
    logic [1:0]                rvalid_q, err_q, err_d;
    logic [1:0][DataWidth-1:0] rdata_q, rdata_d, head;
    logic [1:0]                full, empty, push_req, push_ok, pop_ok, flush, do_push;

    for (genvar f = 0; f < 2; f++) begin : g_fifo
        localparam int R = 1 - f;

        assign full[f]    = (cnt_q[f] == CntFull);
        assign empty[f]   = (cnt_q[f] == '0);
        assign head[f]    = mem_q[f][rptr_q[f]];
        // A flush by the reader wins over a same-cycle push, which is silently dropped.
        assign do_push[f] = push_ok[f] & ~flush[R];
        assign cnt_d[f]   = flush[R] ? '0
                          : cnt_q[f] + CntWidth'(do_push[f]) - CntWidth'(pop_ok[R]);
        assign wptr_d[f]  = flush[R] ? '0 : wptr_q[f] + PtrWidth'(do_push[f]);
        assign rptr_d[f]  = flush[R] ? '0 : rptr_q[f] + PtrWidth'(pop_ok[R]);
    end

    for (genvar s = 0; s < 2; s++) begin : g_side
        localparam int R = 1 - s;

        reg_e                 sel;
        logic                 wr_clr, clr_ovf, wr_irq_en, wr_thresh, err_c;
        logic [CntWidth-1:0]  thresh_eff;
        logic [DataWidth-1:0] rdata_c;

        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        always_comb begin
            sel = RegNone;
            if (addr[s][AddrWidth-1:5] == '0) begin
                case (addr[s][4:2])
                    3'd0:    sel = RegTxData;
                    3'd1:    sel = RegRxData;
                    3'd2:    sel = RegStatus;
                    3'd3:    sel = RegIrqEn;
                    3'd4:    sel = RegThresh;
                    3'd5:    sel = RegClr;
                    default: sel = RegNone;
                endcase
            end
        end

        assign wr_clr      = req[s] & we[s] & (sel == RegClr);
        assign wr_irq_en   = req[s] & we[s] & (sel == RegIrqEn);
        assign wr_thresh   = req[s] & we[s] & (sel == RegThresh);
        assign clr_ovf     = wr_clr & wdata[s][0];
        assign flush[s]    = wr_clr & wdata[s][1];
        assign push_req[s] = req[s] & we[s] & (sel == RegTxData);
        assign push_ok[s]  = push_req[s] & ~full[s];
        assign pop_ok[s]   = req[s] & ~we[s] & (sel == RegRxData) & ~empty[R];

        assign irq_en_d[s] = wr_irq_en ? wdata[s][0] : irq_en_q[s];
        assign thresh_d[s] = wr_thresh ? wdata[s][CntWidth-1:0] : thresh_q[s];
        assign ovf_d[s]    = (ovf_q[s] & ~clr_ovf) | (push_req[s] & full[s]);
        assign thresh_eff  = (thresh_d[s] == '0) ? CntWidth'(1) : thresh_d[s];
        assign irq_d[s]    = irq_en_d[s] & (cnt_d[R] >= thresh_eff);

        always_comb begin
            case (sel)
                RegTxData:           err_c = ~we[s] | full[s];
                RegRxData:           err_c = we[s] | empty[R];
                RegStatus:           err_c = we[s];
                RegIrqEn, RegThresh: err_c = 1'b0;
                RegClr:              err_c = ~we[s];
                default:             err_c = 1'b1;
            endcase
            err_c   = err_c & req[s];
            rdata_c = '0;
            if (req[s] && !we[s] && !err_c) begin
                case (sel)
                    RegRxData: rdata_c = head[R];
                    RegStatus: begin
                        rdata_c[0]               = empty[R];
                        rdata_c[1]               = full[s];
                        rdata_c[2]               = ovf_q[s];
                        rdata_c[8 +: CntWidth]   = cnt_q[R];
                        rdata_c[16 +: CntWidth]  = cnt_q[s];
                    end
                    RegIrqEn:  rdata_c = DataWidth'(irq_en_q[s]);
                    RegThresh: rdata_c = DataWidth'(thresh_q[s]);
                    default:   rdata_c = '0;
                endcase
            end
        end

        assign err_d[s]   = err_c;
        assign rdata_d[s] = rdata_c;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: FIFO storage is cleared on reset as well, so no stale message survives it.
            for (int f = 0; f < 2; f++) begin
                for (int i = 0; i < int'(Depth); i++) begin
                    mem_q[f][i] <= '0;
                end
            end
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            thresh_q <= {2{CntWidth'(1)}};
            irq_en_q <= '0;
            ovf_q    <= '0;
            irq_q    <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            for (int f = 0; f < 2; f++) begin
                if (do_push[f]) begin
                    mem_q[f][wptr_q[f]] <= wdata[f];
                end
            end
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            thresh_q <= thresh_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            rvalid_q <= req;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign a_gnt_o    = a_req_i;
    assign b_gnt_o    = b_req_i;
    assign a_rvalid_o = rvalid_q[0];
    assign b_rvalid_o = rvalid_q[1];
    assign a_rdata_o  = rdata_q[0];
    assign b_rdata_o  = rdata_q[1];
    assign a_err_o    = err_q[0];
    assign b_err_o    = err_q[1];
    assign a_irq_o    = irq_q[0];
    assign b_irq_o    = irq_q[1];

endmodule

// File: tb/tb_carfield_mbox_fifo.sv
// Bench for carfield_mbox_fifo: table-driven accesses on both ports with per-side
// response queues, plus hand-written overflow, flush, IRQ threshold and reset sequences.
module tb_carfield_mbox_fifo;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          a_req_i = 1'b0, a_we_i = 1'b0, b_req_i = 1'b0, b_we_i = 1'b0;
    logic [AW-1:0] a_addr_i = '0, b_addr_i = '0;
    logic [DW-1:0] a_wdata_i = '0, b_wdata_i = '0;
    logic          a_gnt_o, a_rvalid_o, a_err_o, a_irq_o;
    logic          b_gnt_o, b_rvalid_o, b_err_o, b_irq_o;
    logic [DW-1:0] a_rdata_o, b_rdata_o;

    carfield_mbox_fifo #(.DataWidth(DW), .Depth(8), .AddrWidth(AW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .a_req_i    (a_req_i),
        .a_we_i     (a_we_i),
        .a_addr_i   (a_addr_i),
        .a_wdata_i  (a_wdata_i),
        .a_gnt_o    (a_gnt_o),
        .a_rvalid_o (a_rvalid_o),
        .a_rdata_o  (a_rdata_o),
        .a_err_o    (a_err_o),
        .a_irq_o    (a_irq_o),
        .b_req_i    (b_req_i),
        .b_we_i     (b_we_i),
        .b_addr_i   (b_addr_i),
        .b_wdata_i  (b_wdata_i),
        .b_gnt_o    (b_gnt_o),
        .b_rvalid_o (b_rvalid_o),
        .b_rdata_o  (b_rdata_o),
        .b_err_o    (b_err_o),
        .b_irq_o    (b_irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
    } acc_t;

    typedef struct packed {
        acc_t a;
        acc_t b;
        logic irq_a;
        logic irq_b;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [16];

    function automatic acc_t rd(input logic [AW-1:0] addr, input logic [DW-1:0] rdata,
                                input logic err);
        acc_t t;
        t.req = 1'b1; t.we = 1'b0; t.addr = addr; t.wdata = '0;
        t.rdata = rdata; t.err = err;
        return t;
    endfunction

    function automatic acc_t wr(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                input logic err);
        acc_t t;
        t.req = 1'b1; t.we = 1'b1; t.addr = addr; t.wdata = wdata;
        t.rdata = '0; t.err = err;
        return t;
    endfunction

    function automatic acc_t idle();
        acc_t t;
        t = '0;
        return t;
    endfunction

    function automatic vec_t vec(input acc_t a, input acc_t b, input logic irq_a,
                                 input logic irq_b);
        vec_t v;
        v.a = a; v.b = b; v.irq_a = irq_a; v.irq_b = irq_b;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_resp(input string name, input logic rvalid, input logic [DW-1:0] rdata,
                              input logic err, input exp_t e);
        check($sformatf("%s rvalid", name), rvalid, 1'b1);
        check($sformatf("%s rdata", name), rdata, e.rdata);
        check($sformatf("%s err", name), err, e.err);
    endtask

    // One access cycle: drive at posedge+1, score responses and IRQs at the next posedge+1.
    task automatic do_cycle(input vec_t v, input string tag);
        exp_t e;
        a_req_i = v.a.req; a_we_i = v.a.we; a_addr_i = v.a.addr; a_wdata_i = v.a.wdata;
        b_req_i = v.b.req; b_we_i = v.b.we; b_addr_i = v.b.addr; b_wdata_i = v.b.wdata;
        if (v.a.req) begin
            e.rdata = v.a.rdata; e.err = v.a.err;
            sb_a.push_back(e);
        end
        if (v.b.req) begin
            e.rdata = v.b.rdata; e.err = v.b.err;
            sb_b.push_back(e);
        end
        #1;
        check($sformatf("%s a_gnt", tag), a_gnt_o, v.a.req);
        check($sformatf("%s b_gnt", tag), b_gnt_o, v.b.req);
        @(posedge clk_i);
        #1;
        a_req_i = 1'b0; a_we_i = 1'b0;
        b_req_i = 1'b0; b_we_i = 1'b0;
        if (sb_a.size() != 0) begin
            e = sb_a.pop_front();
            check_resp($sformatf("%s a", tag), a_rvalid_o, a_rdata_o, a_err_o, e);
        end else begin
            check($sformatf("%s a_rvalid idle", tag), a_rvalid_o, 1'b0);
        end
        if (sb_b.size() != 0) begin
            e = sb_b.pop_front();
            check_resp($sformatf("%s b", tag), b_rvalid_o, b_rdata_o, b_err_o, e);
        end else begin
            check($sformatf("%s b_rvalid idle", tag), b_rvalid_o, 1'b0);
        end
        check($sformatf("%s a_irq", tag), a_irq_o, v.irq_a);
        check($sformatf("%s b_irq", tag), b_irq_o, v.irq_b);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s a_rvalid", tag), a_rvalid_o, 1'b0);
        check($sformatf("%s b_rvalid", tag), b_rvalid_o, 1'b0);
        check($sformatf("%s a_rdata", tag), a_rdata_o, '0);
        check($sformatf("%s b_rdata", tag), b_rdata_o, '0);
        check($sformatf("%s a_err", tag), a_err_o, 1'b0);
        check($sformatf("%s b_err", tag), b_err_o, 1'b0);
        check($sformatf("%s a_irq", tag), a_irq_o, 1'b0);
        check($sformatf("%s b_irq", tag), b_irq_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        // Basic register behaviour; no IRQ is enabled here so both irq outputs stay low.
        tbl[0]  = vec(rd(12'h010, 32'h1, 1'b0), rd(12'h008, 32'h1, 1'b0), 1'b0, 1'b0);
        tbl[1]  = vec(wr(12'h000, 32'hDEAD_BEEF, 1'b0), idle(), 1'b0, 1'b0);
        tbl[2]  = vec(rd(12'h008, 32'h0001_0001, 1'b0), rd(12'h008, 32'h0000_0100, 1'b0), 1'b0, 1'b0);
        tbl[3]  = vec(idle(), rd(12'h004, 32'hDEAD_BEEF, 1'b0), 1'b0, 1'b0);
        tbl[4]  = vec(rd(12'h00C, 32'h0, 1'b0), rd(12'h008, 32'h1, 1'b0), 1'b0, 1'b0);
        tbl[5]  = vec(rd(12'h020, 32'h0, 1'b1), wr(12'h008, 32'hFFFF, 1'b1), 1'b0, 1'b0);
        tbl[6]  = vec(rd(12'h008, 32'h1, 1'b0), rd(12'h008, 32'h1, 1'b0), 1'b0, 1'b0);
        tbl[7]  = vec(rd(12'h000, 32'h0, 1'b1), wr(12'h004, 32'h1234, 1'b1), 1'b0, 1'b0);
        tbl[8]  = vec(rd(12'h014, 32'h0, 1'b1), rd(12'h004, 32'h0, 1'b1), 1'b0, 1'b0);
        tbl[9]  = vec(wr(12'h014, 32'h3, 1'b0), wr(12'h010, 32'h5, 1'b0), 1'b0, 1'b0);
        tbl[10] = vec(rd(12'h00C, 32'h0, 1'b0), rd(12'h010, 32'h5, 1'b0), 1'b0, 1'b0);
        tbl[11] = vec(rd(12'h408, 32'h0, 1'b1), rd(12'h018, 32'h0, 1'b1), 1'b0, 1'b0);
        tbl[12] = vec(wr(12'h000, 32'h1111_1111, 1'b0), wr(12'h000, 32'h2222_2222, 1'b0), 1'b0, 1'b0);
        tbl[13] = vec(rd(12'h004, 32'h2222_2222, 1'b0), rd(12'h004, 32'h1111_1111, 1'b0), 1'b0, 1'b0);
        tbl[14] = vec(wr(12'h003, 32'h77, 1'b0), idle(), 1'b0, 1'b0);
        tbl[15] = vec(idle(), rd(12'h006, 32'h77, 1'b0), 1'b0, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("init_rst");
        rst_ni = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_cycle(tbl[i], $sformatf("tbl%0d", i));
        end

        // Overflow of AB: ninth push rejected and sticky overflow raised.
        for (int i = 0; i < 9; i++) begin
            do_cycle(vec(wr(12'h000, 32'hA000_0000 + i, i == 8), idle(), 1'b0, 1'b0),
                     $sformatf("ovf_push%0d", i));
        end
        do_cycle(vec(rd(12'h008, 32'h0008_0007, 1'b0), rd(12'h008, 32'h0000_0800, 1'b0), 1'b0, 1'b0),
                 "ovf_status");
        for (int i = 0; i < 9; i++) begin
            do_cycle(vec(idle(), rd(12'h004, (i < 8) ? 32'hA000_0000 + i : 32'h0, i == 8), 1'b0, 1'b0),
                     $sformatf("drain_pop%0d", i));
        end
        do_cycle(vec(wr(12'h014, 32'h1, 1'b0), idle(), 1'b0, 1'b0), "clr_ovf");
        do_cycle(vec(rd(12'h008, 32'h1, 1'b0), rd(12'h008, 32'h1, 1'b0), 1'b0, 1'b0), "clr_status");

        // Refill (pointers wrap), then push-to-full racing a pop.
        for (int i = 0; i < 8; i++) begin
            do_cycle(vec(wr(12'h000, 32'hC000_0000 + i, 1'b0), idle(), 1'b0, 1'b0),
                     $sformatf("fill_push%0d", i));
        end
        do_cycle(vec(wr(12'h000, 32'hBBBB_BBBB, 1'b1), rd(12'h004, 32'hC000_0000, 1'b0), 1'b0, 1'b0),
                 "full_race");
        do_cycle(vec(rd(12'h008, 32'h0007_0005, 1'b0), idle(), 1'b0, 1'b0), "race_status");
        do_cycle(vec(wr(12'h000, 32'hD000_0000, 1'b0), rd(12'h004, 32'hC000_0001, 1'b0), 1'b0, 1'b0),
                 "push_pop_same");
        do_cycle(vec(rd(12'h008, 32'h0007_0005, 1'b0), idle(), 1'b0, 1'b0), "same_status");

        // Flush of b's RX with a racing push from a, then empty-pop racing a push.
        do_cycle(vec(wr(12'h000, 32'hE, 1'b0), wr(12'h014, 32'h2, 1'b0), 1'b0, 1'b0), "flush_race");
        do_cycle(vec(rd(12'h008, 32'h0000_0005, 1'b0), rd(12'h008, 32'h1, 1'b0), 1'b0, 1'b0),
                 "flush_status");
        do_cycle(vec(idle(), rd(12'h004, 32'h0, 1'b1), 1'b0, 1'b0), "flush_pop");
        do_cycle(vec(wr(12'h000, 32'hF0, 1'b0), rd(12'h004, 32'h0, 1'b1), 1'b0, 1'b0), "empty_race");
        do_cycle(vec(idle(), rd(12'h004, 32'hF0, 1'b0), 1'b0, 1'b0), "empty_race_pop");

        // IRQ threshold on b: rises at count 3, falls at 2; THRESH=0 behaves as 1.
        do_cycle(vec(idle(), wr(12'h00C, 32'h1, 1'b0), 1'b0, 1'b0), "irq_en");
        do_cycle(vec(idle(), wr(12'h010, 32'h3, 1'b0), 1'b0, 1'b0), "irq_thresh3");
        do_cycle(vec(wr(12'h000, 32'h31, 1'b0), idle(), 1'b0, 1'b0), "irq_push1");
        do_cycle(vec(wr(12'h000, 32'h32, 1'b0), idle(), 1'b0, 1'b0), "irq_push2");
        do_cycle(vec(wr(12'h000, 32'h33, 1'b0), idle(), 1'b0, 1'b1), "irq_push3");
        do_cycle(vec(idle(), rd(12'h004, 32'h31, 1'b0), 1'b0, 1'b0), "irq_pop_to2");
        do_cycle(vec(idle(), wr(12'h010, 32'h0, 1'b0), 1'b0, 1'b1), "irq_thresh0");
        do_cycle(vec(idle(), rd(12'h010, 32'h0, 1'b0), 1'b0, 1'b1), "irq_thresh_rd");
        do_cycle(vec(idle(), rd(12'h004, 32'h32, 1'b0), 1'b0, 1'b1), "irq_pop_to1");
        do_cycle(vec(idle(), rd(12'h004, 32'h33, 1'b0), 1'b0, 1'b0), "irq_pop_to0");

        // Reset with five words queued, b_irq high and a read in flight.
        for (int i = 0; i < 5; i++) begin
            do_cycle(vec(wr(12'h000, 32'h50 + i, 1'b0), idle(), 1'b0, 1'b1),
                     $sformatf("rst_fill%0d", i));
        end
        b_req_i = 1'b1; b_we_i = 1'b0; b_addr_i = 12'h004;
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk_i);
        #1;
        b_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("held_rst");
        rst_ni = 1'b1;
        do_cycle(vec(idle(), idle(), 1'b0, 1'b0), "post_rst_idle");
        do_cycle(vec(rd(12'h008, 32'h1, 1'b0), rd(12'h008, 32'h1, 1'b0), 1'b0, 1'b0), "post_rst_status");
        do_cycle(vec(rd(12'h010, 32'h1, 1'b0), rd(12'h010, 32'h1, 1'b0), 1'b0, 1'b0), "post_rst_thresh");
        do_cycle(vec(rd(12'h00C, 32'h0, 1'b0), rd(12'h004, 32'h0, 1'b1), 1'b0, 1'b0), "post_rst_rx");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/carfield_mbox_fifo.md
CARFIELD_MBOX_FIFO -- requirements
Module: carfield_mbox_fifo

Interface
REQ-001 SHALL have parameter DataWidth, default 32, message word width.
REQ-002 SHALL have parameter Depth, default 8, entries per direction FIFO; power of two, 2..64.
REQ-003 SHALL have parameter AddrWidth, default 12, register port address width (4 KiB window).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports a_req_i / b_req_i  input  1  register request, host side (a) / island side (b).
REQ-007 SHALL have ports a_we_i / b_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports a_addr_i / b_addr_i  input  AddrWidth  byte address; bits [1:0] ignored.
REQ-009 SHALL have ports a_wdata_i / b_wdata_i  input  DataWidth  write data.
REQ-010 SHALL have ports a_gnt_o / b_gnt_o  output  1  grant, combinationally equal to req.
REQ-011 SHALL have ports a_rvalid_o / b_rvalid_o  output  1  response valid, exactly one cycle after grant.
REQ-012 SHALL have ports a_rdata_o / b_rdata_o  output  DataWidth  registered read data.
REQ-013 SHALL have ports a_err_o / b_err_o  output  1  response error, qualified by rvalid.
REQ-014 SHALL have ports a_irq_o / b_irq_o  output  1  level interrupt to that side's receiver, registered.

Function
REQ-015 SHALL contain two independent FIFOs: AB (a pushes, b pops) and BA (b pushes, a pops), Depth x DataWidth each, count width $clog2(Depth)+1.
REQ-016 SHALL decode per side at offset 0x00 TXDATA (W: push own TX FIFO), 0x04 RXDATA (R: pop own RX FIFO), 0x08 STATUS (R), 0x0C IRQ_EN (RW, bit0), 0x10 THRESH (RW, $clog2(Depth)+1 bits), 0x14 CLR (W1: bit0 clears own overflow flag, bit1 flushes own RX FIFO).
REQ-017 SHALL define STATUS = {rx_count at [15:8], tx_count at [23:16], overflow at bit2, tx_full at bit1, rx_empty at bit0}, other bits 0.
REQ-018 SHALL complete every granted access with rvalid in the following cycle; no back-pressure, no outstanding beyond one.
REQ-019 SHALL return rdata = 0 on writes and on any errored access.
REQ-020 SHALL flag err=1 for: unmapped offset; write to RXDATA/STATUS; read of TXDATA/CLR; RXDATA read while RX empty (no pop); TXDATA write while TX full (word dropped, sets writer's sticky overflow).
REQ-021 SHALL evaluate full/empty on the pre-cycle count: push to a full FIFO is rejected even if the reader pops in the same cycle; pop from an empty FIFO is rejected even if the writer pushes in the same cycle.
REQ-022 SHALL allow simultaneous accepted push and pop on one FIFO; count unchanged, both data paths correct.
REQ-023 SHALL wrap read/write pointers modulo Depth.
REQ-024 SHALL, on RX flush, zero the RX FIFO count/pointers; a same-cycle push from the other side is dropped without error.
REQ-025 SHALL drive x_irq_o next cycle = IRQ_EN[0] & (rx_count >= max(THRESH,1)), using post-update count.
REQ-026 SHALL have pop latency: RXDATA read data equals FIFO head at grant cycle, presented on rdata with rvalid.

Reset
REQ-027 SHALL, while rst_ni low, clear both FIFOs, pointers, counts, overflow flags, IRQ_EN=0, THRESH=1, rvalid=0, rdata=0, err=0, irq=0.
REQ-028 SHALL apply reset asynchronously at any cycle, including mid-access; the pending response is discarded (no rvalid after release).
REQ-029 SHALL accept a request in the first cycle after rst_ni deasserts.

Verification
REQ-030 SHALL cover: a writes 0xDEAD_BEEF to 0x00, b reads 0x04 -> b rdata 0xDEADBEEF, err 0; b STATUS rx_empty=1 afterwards.
REQ-031 SHALL cover: a writes 9 words (Depth 8) -> 9th err=1, a STATUS overflow=1, b reads 8 words in order, 9th read err=1 rdata 0.
REQ-032 SHALL cover: AB full, a pushes and b pops same cycle -> push err=1, pop returns oldest word, tx_count=7.
REQ-033 SHALL cover: b IRQ_EN=1, THRESH=3 -> b_irq_o rises the cycle after the 3rd a push, falls the cycle after b pops down to 2.
REQ-034 SHALL cover: read 0x20 and write 0x08 -> err=1, rdata 0, no state change.
REQ-035 SHALL cover: rst_ni pulsed low with 5 words queued and a read pending -> no rvalid, counts 0, irq 0, THRESH reads 1.
